// File: rtl/hog_regs_pkg.sv
// rtl/hog_regs_pkg.sv - register map constants and helpers for the HOG AXI-Lite register file
package hog_regs_pkg;

    localparam logic [2:0] CTRL_IDX   = 3'd0;
    localparam logic [2:0] STATUS_IDX = 3'd1;
    localparam logic [2:0] WIDTH_IDX  = 3'd2;
    localparam logic [2:0] HEIGHT_IDX = 3'd3;
    localparam logic [2:0] SRC_IDX    = 3'd4;
    localparam logic [2:0] DST_IDX    = 3'd5;
    localparam logic [2:0] IRQ_IDX    = 3'd6;
    localparam logic [2:0] ID_IDX     = 3'd7;

    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_DONE_BIT  = 1;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [31:0] HOG_ID_DEFAULT = 32'h484F_4701;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_e;

    function automatic logic [7:0] merge_byte(input logic [7:0] old_val,
                                              input logic [7:0] new_val,
                                              input logic       en);
        return en ? new_val : old_val;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = merge_byte(old_val[b*8 +: 8], new_val[b*8 +: 8], strb[b]);
        end
        return res;
    endfunction

endpackage

// File: rtl/hog_axil_wr_ctrl.sv
// rtl/hog_axil_wr_ctrl.sv - AXI-Lite AW/W capture and B response, emits a single-cycle write strobe
module hog_axil_wr_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic                    wr_en_o,
    output logic [ADDR_WIDTH-1:0]   wr_addr_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic [DATA_WIDTH/8-1:0] wr_strb_o
);

    logic                    aw_valid_q, aw_valid_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic                    w_valid_q, w_valid_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
    logic                    bvalid_q, bvalid_d;

    assign s_axi_awready = !aw_valid_q && !bvalid_q;
    assign s_axi_wready  = !w_valid_q && !bvalid_q;
    assign s_axi_bvalid  = bvalid_q;

    // Latches stay full while the response is pending, so bvalid_q gates repeat strobes.
    assign wr_en_o   = aw_valid_q && w_valid_q && !bvalid_q;
    assign wr_addr_o = aw_addr_q;
    assign wr_data_o = w_data_q;
    assign wr_strb_o = w_strb_q;

    always_comb begin
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        w_valid_d  = w_valid_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        if (s_axi_awvalid && s_axi_awready) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = s_axi_awaddr;
        end
        if (s_axi_wvalid && s_axi_wready) begin
            w_valid_d = 1'b1;
            w_data_d  = s_axi_wdata;
            w_strb_d  = s_axi_wstrb;
        end
        if (wr_en_o) begin
            bvalid_d = 1'b1;
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d   = 1'b0;
            aw_valid_d = 1'b0;
            w_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
        end else begin
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
        end
    end

endmodule

// File: rtl/hog_axil_regs.sv
// rtl/hog_axil_regs.sv - HOG accelerator AXI-Lite register file; HOG_AXIL_IRQ_EN adds irq_o and IRQ_ENABLE
module hog_axil_regs
    import hog_regs_pkg::*;
#(
    parameter int          C_S_AXI_GP_DATA_WIDTH = 32,
    parameter int          C_S_AXI_GP_ADDR_WIDTH = 5,
    parameter logic [31:0] HOG_ID_VALUE          = HOG_ID_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                         s_axi_awprot,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_GP_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                         s_axi_arprot,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
`ifdef HOG_AXIL_IRQ_EN
    output logic                               irq_o,
`endif
    output logic                               start_o,
    output logic [15:0]                        width_o,
    output logic [15:0]                        height_o,
    output logic [31:0]                        src_addr_o,
    output logic [31:0]                        dst_addr_o,
    input  logic                               ready_i,
    input  logic                               done_i
);

    logic                               wr_en;
    logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_S_AXI_GP_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_GP_DATA_WIDTH/8-1:0] wr_strb;
    logic [2:0]                         wr_idx;
    logic [2:0]                         rd_idx;

    hog_axil_wr_ctrl #(
        .ADDR_WIDTH(C_S_AXI_GP_ADDR_WIDTH),
        .DATA_WIDTH(C_S_AXI_GP_DATA_WIDTH)
    ) u_wr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_strb_o    (wr_strb)
    );

    assign wr_idx      = wr_addr[4:2];
    assign rd_idx      = s_axi_araddr[4:2];
    assign s_axi_bresp = RESP_OKAY;
    assign s_axi_rresp = RESP_OKAY;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[1:0], wr_addr[1:0]};

    logic        start_q, start_d;
    logic        done_q, done_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
`ifdef HOG_AXIL_IRQ_EN
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
`endif

    always_comb begin
        start_d  = 1'b0;
        done_d   = done_q;
        width_d  = width_q;
        height_d = height_q;
        src_d    = src_q;
        dst_d    = dst_q;
`ifdef HOG_AXIL_IRQ_EN
        irq_en_d = irq_en_q;
        irq_d    = done_q && irq_en_q;
`endif
        if (wr_en) begin
            case (wr_idx)
                CTRL_IDX:   start_d = wr_strb[0] && wr_data[0] && ready_i;
                STATUS_IDX: if (wr_strb[0] && wr_data[STATUS_DONE_BIT]) done_d = 1'b0;
                WIDTH_IDX:  width_d = {merge_byte(width_q[15:8], wr_data[15:8], wr_strb[1]),
                                       merge_byte(width_q[7:0], wr_data[7:0], wr_strb[0])};
                HEIGHT_IDX: height_d = {merge_byte(height_q[15:8], wr_data[15:8], wr_strb[1]),
                                        merge_byte(height_q[7:0], wr_data[7:0], wr_strb[0])};
                SRC_IDX:    src_d = apply_wstrb(src_q, wr_data, wr_strb);
                DST_IDX:    dst_d = apply_wstrb(dst_q, wr_data, wr_strb);
`ifdef HOG_AXIL_IRQ_EN
                IRQ_IDX:    if (wr_strb[0]) irq_en_d = wr_data[0];
`endif
                default: ;
            endcase
        end
        // A completion pulse outranks a simultaneous software clear.
        if (done_i) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
`ifdef HOG_AXIL_IRQ_EN
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
`endif
        end else begin
            start_q  <= start_d;
            done_q   <= done_d;
            width_q  <= width_d;
            height_q <= height_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
`ifdef HOG_AXIL_IRQ_EN
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
`endif
        end
    end

    assign start_o    = start_q;
    assign width_o    = width_q;
    assign height_o   = height_q;
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
`ifdef HOG_AXIL_IRQ_EN
    assign irq_o      = irq_q;
`endif

    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            STATUS_IDX: begin
                rd_mux[STATUS_READY_BIT] = ready_i;
                rd_mux[STATUS_DONE_BIT]  = done_q;
            end
            WIDTH_IDX:  rd_mux = {16'h0, width_q};
            HEIGHT_IDX: rd_mux = {16'h0, height_q};
            SRC_IDX:    rd_mux = src_q;
            DST_IDX:    rd_mux = dst_q;
`ifdef HOG_AXIL_IRQ_EN
            IRQ_IDX:    rd_mux = {31'h0, irq_en_q};
`endif
            ID_IDX:     rd_mux = HOG_ID_VALUE;
            default:    rd_mux = '0;
        endcase
    end

    rd_state_e   rd_state_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    // rdata is captured from the pre-edge register values, so a concurrent write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: if (s_axi_arvalid) begin
                    rdata_q    <= rd_mux;
                    rvalid_q   <= 1'b1;
                    rd_state_q <= R_VALID;
                end
                R_VALID: if (s_axi_rready) begin
                    rvalid_q   <= 1'b0;
                    rd_state_q <= R_IDLE;
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_arready = (rd_state_q == R_IDLE);
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_hog_axil_regs.sv
// tb/tb_hog_axil_regs.sv - directed self-checking bench for hog_axil_regs
module tb_hog_axil_regs;

    logic        clk;
    logic        rst;
    logic [4:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [4:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        start_o;
    logic [15:0] width_o;
    logic [15:0] height_o;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic        ready_i;
    logic        done_i;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;

    hog_axil_regs dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .start_o      (start_o),
        .width_o      (width_o),
        .height_o     (height_o),
        .src_addr_o   (src_addr_o),
        .dst_addr_o   (dst_addr_o),
        .ready_i      (ready_i),
        .done_i       (done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (start_o) start_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_start(input logic [4:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int mode);
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        if (mode == 0) begin
            s_axi_awvalid = 1'b1;
            s_axi_wvalid  = 1'b1;
            for (int i = 0; i < 20 && !(s_axi_awready && s_axi_wready); i++) tick;
            chk("aw_w_ready", {s_axi_awready, s_axi_wready}, 2'b11);
            tick;
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if ((ch == 0) == (mode == 1)) begin
                    s_axi_awvalid = 1'b1;
                    for (int i = 0; i < 20 && !s_axi_awready; i++) tick;
                    chk("awready", s_axi_awready, 1);
                    tick;
                    s_axi_awvalid = 1'b0;
                end else begin
                    s_axi_wvalid = 1'b1;
                    for (int i = 0; i < 20 && !s_axi_wready; i++) tick;
                    chk("wready", s_axi_wready, 1);
                    tick;
                    s_axi_wvalid = 1'b0;
                end
                if (ch == 0) tick;
            end
        end
    endtask

    task automatic write_finish;
        for (int i = 0; i < 20 && !s_axi_bvalid; i++) tick;
        chk("bvalid", s_axi_bvalid, 1);
        chk("bresp", s_axi_bresp, 0);
        s_axi_bready = 1'b1;
        tick;
        s_axi_bready = 1'b0;
        chk("bvalid_drop", s_axi_bvalid, 0);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode);
        write_start(addr, data, strb, mode);
        write_finish();
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        chk("arready", s_axi_arready, 1);
        tick;
        s_axi_arvalid = 1'b0;
        chk("rvalid_lat1", s_axi_rvalid, 1);
        chk("rresp", s_axi_rresp, 0);
        data = s_axi_rdata;
        s_axi_rready = 1'b1;
        tick;
        s_axi_rready = 1'b0;
        chk("rvalid_drop", s_axi_rvalid, 0);
    endtask

    logic [31:0] rd;
    int          cnt0;

    initial begin
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        ready_i = 1'b0; done_i = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_outs", {start_o, width_o, height_o}, 0);
        chk("rst_src", src_addr_o, 0);
        chk("rst_dst", dst_addr_o, 0);
        tick;

        for (int a = 0; a < 8; a++) begin
            axi_read(5'(a * 4), rd);
            chk($sformatf("rd_reset_%0d", a), rd, (a == 7) ? 32'h484F_4701 : 32'h0);
        end

        for (int m = 0; m < 3; m++) begin
            axi_write(5'h08, 32'h0, 4'hF, 0);
            axi_write(5'h0C, 32'h0, 4'hF, 0);
            chk($sformatf("clr_%0d", m), {width_o, height_o}, 0);
            axi_write(5'h08, 32'd640, 4'hF, m);
            axi_write(5'h0C, 32'd480, 4'hF, m);
            chk($sformatf("width_mode%0d", m), width_o, 640);
            chk($sformatf("height_mode%0d", m), height_o, 480);
        end
        axi_read(5'h0B, rd);
        chk("rd_width_lowbits_ignored", rd, 640);

        axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(5'h10, 32'h1000_0000, 4'b0011, 1);
        axi_read(5'h10, rd);
        chk("src_strb_rd", rd, 32'hFFFF_0000);
        chk("src_strb_out", src_addr_o, 32'hFFFF_0000);
        axi_write(5'h14, 32'hA5A5_1234, 4'b1100, 2);
        chk("dst_strb_out", dst_addr_o, 32'hA5A5_0000);

        axi_write(5'h1C, 32'h1234_5678, 4'hF, 0);
        axi_read(5'h1C, rd);
        chk("id_ro", rd, 32'h484F_4701);
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(5'h18, rd);
        chk("irq_reserved", rd, 0);

        ready_i = 1'b1;
        cnt0 = start_cnt;
        axi_write(5'h00, 32'h1, 4'hF, 0);
        repeat (3) tick;
        chk("start_pulse_cnt", start_cnt - cnt0, 1);
        axi_read(5'h00, rd);
        chk("ctrl_reads0", rd, 0);
        ready_i = 1'b0;
        cnt0 = start_cnt;
        axi_write(5'h00, 32'h1, 4'hF, 0);
        repeat (3) tick;
        chk("start_dropped", start_cnt - cnt0, 0);
        ready_i = 1'b1;
        cnt0 = start_cnt;
        axi_write(5'h00, 32'h1, 4'hE, 0);
        repeat (3) tick;
        chk("start_no_strb0", start_cnt - cnt0, 0);

        done_i = 1'b1;
        tick;
        done_i = 1'b0;
        axi_read(5'h04, rd);
        chk("status_done", rd, 32'h3);
        write_start(5'h04, 32'h2, 4'hF, 0);
        done_i = 1'b1;
        tick;
        done_i = 1'b0;
        write_finish();
        axi_read(5'h04, rd);
        chk("status_set_wins", rd, 32'h3);
        axi_write(5'h04, 32'h2, 4'hE, 0);
        axi_read(5'h04, rd);
        chk("status_w1c_nostrb", rd, 32'h3);
        axi_write(5'h04, 32'h2, 4'hF, 0);
        axi_read(5'h04, rd);
        chk("status_w1c", rd, 32'h1);

        write_start(5'h08, 32'd1920, 4'hF, 0);
        for (int i = 0; i < 20 && !s_axi_bvalid; i++) tick;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_%0d", i), {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b100);
            tick;
        end
        chk("hold_width", width_o, 1920);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_bvalid", s_axi_bvalid, 0);
        chk("midrst_regs", {width_o, height_o}, 0);
        chk("midrst_src_dst", src_addr_o | dst_addr_o, 0);
        tick;
        axi_read(5'h04, rd);
        chk("midrst_status", rd, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hog_axil_regs.md
Name: hog_axil_regs

Overview:
- AXI4-Lite GP slave register file for the HOG accelerator.
- Downstream consumer of the axil_gp_if bus from the PS; converts bus transactions into core-side control and configuration.
- Drives image geometry, DDR base addresses and a start pulse to the HOG core, and returns core status to software.

Parameters:
- C_S_AXI_GP_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- C_S_AXI_GP_ADDR_WIDTH, 5, byte address width; gives 8 word registers.
- HOG_ID_VALUE, 32'h484F_4701, constant returned by the ID register.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_axi_awaddr  in  5  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte lane enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  5  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- start_o  out  1  one-cycle start pulse to core
- width_o  out  16  image width in pixels
- height_o  out  16  image height in pixels
- src_addr_o  out  32  DDR input base address
- dst_addr_o  out  32  DDR output base address
- ready_i  in  1  core idle and able to accept start
- done_i  in  1  one-cycle pulse at frame completion

Behaviour:
- Register map, word index = addr[4:2]:
  - 0 CTRL: bit0 START, write-1 self-clearing; reads 0.
  - 1 STATUS: bit0 READY (RO, mirrors ready_i); bit1 DONE (sticky, write-1-to-clear).
  - 2 WIDTH [15:0], RW.
  - 3 HEIGHT [15:0], RW.
  - 4 SRC_ADDR, RW.
  - 5 DST_ADDR, RW.
  - 6 IRQ (see Optional Feature); otherwise reads 0, writes ignored.
  - 7 ID, RO, returns HOG_ID_VALUE.
- addr[1:0] is ignored.
- Byte strobes apply to all RW registers. For CTRL and STATUS, a write takes effect only if wstrb[0] is set.
- Reset values: all outputs 0, all registers 0, bresp and rresp 2'b00.
- Write channel:
  - AW and W are captured independently.
  - awready is high while no address is latched and bvalid is low; wready follows the same rule for data.
  - Address and data may arrive in the same cycle or in either order.
  - The register update happens in the cycle after both are latched; bvalid rises in that same cycle.
  - bvalid holds until bready is high, then both latches clear.
  - At most one write is outstanding.
- Read channel:
  - States R_IDLE and R_VALID.
  - arready is 1 in R_IDLE. arvalid in R_IDLE latches rdata and moves to R_VALID with rvalid=1 on the next cycle (latency 1).
  - rdata holds stable until rready is high, then return to R_IDLE.
- Responses are always OKAY. Unmapped or RO writes are dropped; reserved bits read 0.
- start_o pulses for exactly 1 cycle, the cycle after the CTRL write completes, only if ready_i=1 at that moment. Otherwise the start is dropped silently.
- DONE is set by done_i. A W1C and done_i in the same cycle leave DONE set (set wins).
- A read and a write in the same cycle proceed concurrently. The read returns the pre-write value.
- rst mid-transaction returns both channels to idle, drops pending bvalid/rvalid, and clears all registers.

Optional Feature:
- Macro: HOG_AXIL_IRQ_EN.
- When defined:
  - Adds port irq_o (out, 1).
  - Register 6 bit0 is IRQ_ENABLE (RW).
  - irq_o = DONE & IRQ_ENABLE, registered, so it rises 1 cycle after DONE sets and clears 1 cycle after the W1C.
- When undefined: no irq_o port, and register 6 is reserved.

Decomposition:
- hog_regs_pkg holds:
  - register index localparams (CTRL_IDX … ID_IDX)
  - STATUS bit positions
  - OKAY response constant
  - HOG_ID_VALUE default
- One natural sub-module: hog_axil_wr_ctrl, which covers AW/W capture and B response and outputs a single-cycle write strobe with address, data and strobe.
- Read path and register storage stay in the top module.

Test Plan:
- After reset, read each of the 8 addresses -> 0 for all except ID = 32'h484F_4701; rresp=0; rvalid exactly 1 cycle after the arvalid/arready handshake.
- Write WIDTH=640 and HEIGHT=480 with AW before W, W before AW, and both together -> width_o=640 and height_o=480 in each case, one bvalid per write, bresp=0.
- Write SRC_ADDR=32'h1000_0000 with wstrb=4'b0011 after 32'hFFFF_FFFF -> readback 32'hFFFF_0000.
- With ready_i=1, write CTRL=1 -> start_o high exactly 1 cycle. Repeat with ready_i=0 -> start_o stays 0.
- Pulse done_i -> STATUS reads 2'b11. Write STATUS=2 in the same cycle as a second done_i -> DONE stays 1. Write STATUS=2 alone -> DONE clears.
- Hold bready=0 for 5 cycles -> bvalid held and awready/wready stay low. Assert rst mid-hold -> bvalid 0 and registers 0 on the next cycle.
